pma_lookup_sched: RTL and testbench

- Shared, time-multiplexed PMA region lookup engine for fetch and LSU.
- Each cycle it evaluates one rule index across all four region classes: non-idempotent, execute, cached, shared.
- It scans the rule tables held in CVA6Cfg, then returns a 4-bit attribute vector.
- Replaces per-requester parallel 16-rule comparator trees with 4 comparators plus a round-robin arbiter.

---
 rtl/pma_lookup_sched.sv | 226 ++++++++++++++++++++++
 tb/tb_pma_lookup_sched.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pma_lookup_sched.sv
// pma_lookup_sched: shared PMA region lookup engine for fetch and LSU.
// One rule index per cycle is checked for all four region classes, so
// only four range comparators are needed; a round-robin arbiter picks
// the requester that owns the engine.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   flush_i        abort any lookup in flight, block new grants
//   req_valid_i    per-port lookup request
//   req_addr_i     per-port 64-bit physical address
//   req_ready_o    per-port grant (one-hot or zero)
//   rsp_valid_o    per-port response valid (at most one bit)
//   rsp_ready_i    per-port response accept
//   rsp_attr_o     {shared, cached, exec, nonidem}
//   busy_o         engine is scanning or holding a response
//
// Optional macro PMA_LOOKUP_EARLY_EXIT_EN: stop the scan as soon as no
// remaining rule index can change any of the four attribute flags.

package config_pkg;

    localparam int unsigned NrMaxRules = 16;

    typedef struct packed {
        int unsigned                 NrNonIdempotentRules;
        logic [NrMaxRules-1:0][63:0] NonIdempotentAddrBase;
        logic [NrMaxRules-1:0][63:0] NonIdempotentLength;
        int unsigned                 NrExecuteRegionRules;
        logic [NrMaxRules-1:0][63:0] ExecuteRegionAddrBase;
        logic [NrMaxRules-1:0][63:0] ExecuteRegionLength;
        int unsigned                 NrCachedRegionRules;
        logic [NrMaxRules-1:0][63:0] CachedRegionAddrBase;
        logic [NrMaxRules-1:0][63:0] CachedRegionLength;
        int unsigned                 NrSharedRegionRules;
        logic [NrMaxRules-1:0][63:0] SharedRegionAddrBase;
        logic [NrMaxRules-1:0][63:0] SharedRegionLength;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

module pma_lookup_sched #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned NrPorts = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic [NrPorts-1:0]       req_valid_i,
    input  logic [NrPorts-1:0][63:0] req_addr_i,
    output logic [NrPorts-1:0]       req_ready_o,
    output logic [NrPorts-1:0]       rsp_valid_o,
    input  logic [NrPorts-1:0]       rsp_ready_i,
    output logic [3:0]               rsp_attr_o,
    output logic                     busy_o
);

    localparam int unsigned KW = $clog2(config_pkg::NrMaxRules);
    localparam int unsigned PW = (NrPorts > 1) ? $clog2(NrPorts) : 1;

    // Rule counts, indexed like the attribute vector.
    localparam logic [3:0][31:0] NrC = {
        CVA6Cfg.NrSharedRegionRules,
        CVA6Cfg.NrCachedRegionRules,
        CVA6Cfg.NrExecuteRegionRules,
        CVA6Cfg.NrNonIdempotentRules
    };

    function automatic int unsigned max2(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned NRaw = max2(max2(NrC[0], NrC[1]),
                                        max2(NrC[2], NrC[3]));
    localparam int unsigned N = (NRaw == 0) ? 1 : NRaw;
    localparam logic [KW-1:0] KLast = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [3:0]      flags_q, flags_d;
    logic [63:0]     addr_q, addr_d;
    logic [PW-1:0]   port_q, port_d;
    logic [PW-1:0]   rr_q, rr_d;

    logic [NrPorts-1:0] gnt;
    logic [PW-1:0]      gnt_id;
    logic [PW-1:0]      cand;
    logic               found;

    logic [3:0][63:0] base;
    logic [3:0][63:0] len;
    logic [3:0]       hit;
    logic [3:0]       flags_nxt;
    logic             early;

    // Round-robin search starting at the priority pointer.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < NrPorts; i++) begin
            cand = PW'((32'(rr_q) + 32'(i)) % NrPorts);
            if (!found && req_valid_i[cand]) begin
                found  = 1'b1;
                gnt_id = cand;
            end
        end
        if (found) begin
            gnt[gnt_id] = 1'b1;
        end
    end

    // The four shared comparators, all looking at rule index k.
    always_comb begin
        base[0] = CVA6Cfg.NonIdempotentAddrBase[k_q];
        len[0]  = CVA6Cfg.NonIdempotentLength[k_q];
        base[1] = CVA6Cfg.ExecuteRegionAddrBase[k_q];
        len[1]  = CVA6Cfg.ExecuteRegionLength[k_q];
        base[2] = CVA6Cfg.CachedRegionAddrBase[k_q];
        len[2]  = CVA6Cfg.CachedRegionLength[k_q];
        base[3] = CVA6Cfg.SharedRegionAddrBase[k_q];
        len[3]  = CVA6Cfg.SharedRegionLength[k_q];
        for (int c = 0; c < 4; c++) begin
            // 65-bit upper bound: a region ending at 2^64 never wraps.
            hit[c] = (32'(k_q) < NrC[c])
                  && (addr_q >= base[c])
                  && ({1'b0, addr_q} < ({1'b0, base[c]} + {1'b0, len[c]}));
        end
        flags_nxt = flags_q | hit;
    end

`ifdef PMA_LOOKUP_EARLY_EXIT_EN
    // A class is settled once its flag is set or its last rule has
    // just been checked; classes without rules are always settled.
    logic [3:0] settled;
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            settled[c] = flags_nxt[c] || ((32'(k_q) + 32'd1) >= NrC[c]);
        end
        early = &settled;
    end
`else
    assign early = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        flags_d = flags_q;
        addr_d  = addr_q;
        port_d  = port_q;
        rr_d    = rr_q;
        unique case (state_q)
            IDLE: begin
                if (!flush_i && found) begin
                    state_d = SCAN;
                    k_d     = '0;
                    flags_d = '0;
                    addr_d  = req_addr_i[gnt_id];
                    port_d  = gnt_id;
                    rr_d    = PW'((32'(gnt_id) + 32'd1) % NrPorts);
                end
            end
            SCAN: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    flags_d = flags_nxt;
                    if (k_q == KLast || early) begin
                        state_d = RESP;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            RESP: begin
                if (flush_i || rsp_ready_i[port_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            flags_q <= '0;
            addr_q  <= '0;
            port_q  <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            flags_q <= flags_d;
            addr_q  <= addr_d;
            port_q  <= port_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        rsp_attr_o  = '0;
        req_ready_o = '0;
        if (state_q == IDLE && !flush_i) begin
            req_ready_o = gnt;
        end
        if (state_q == RESP) begin
            rsp_valid_o[port_q] = 1'b1;
            rsp_attr_o          = flags_q;
        end
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_pma_lookup_sched.sv
// Directed testbench for pma_lookup_sched.
// Three-rule scan table; checks grant, latency, attributes, arbitration.

module tb_pma_lookup_sched;

    function automatic config_pkg::cva6_cfg_t mk_cfg();
        config_pkg::cva6_cfg_t c;
        c = '0;
        c.NrNonIdempotentRules     = 2;
        c.NonIdempotentAddrBase[0] = 64'h0;
        c.NonIdempotentLength[0]   = 64'h1000;
        c.NonIdempotentAddrBase[1] = 64'h1000_0000;
        c.NonIdempotentLength[1]   = 64'h100;
        c.NrExecuteRegionRules     = 3;
        c.ExecuteRegionAddrBase[0] = 64'h1_0000;
        c.ExecuteRegionLength[0]   = 64'h1_0000;
        c.ExecuteRegionAddrBase[1] = 64'h8000_0000;
        c.ExecuteRegionLength[1]   = 64'h4000_0000;
        c.ExecuteRegionAddrBase[2] = 64'h0;
        c.ExecuteRegionLength[2]   = 64'h1000;
        c.NrCachedRegionRules      = 1;
        c.CachedRegionAddrBase[0]  = 64'h8000_0000;
        c.CachedRegionLength[0]    = 64'h4000_0000;
        c.NrSharedRegionRules      = 0;
        return c;
    endfunction

    localparam config_pkg::cva6_cfg_t Cfg = mk_cfg();

`ifdef PMA_LOOKUP_EARLY_EXIT_EN
    localparam int LatHit = 3;
`else
    localparam int LatHit = 4;
`endif

    logic             clk_i;
    logic             rst_i;
    logic             flush_i;
    logic [1:0]       req_valid_i;
    logic [1:0][63:0] req_addr_i;
    logic [1:0]       req_ready_o;
    logic [1:0]       rsp_valid_o;
    logic [1:0]       rsp_ready_i;
    logic [3:0]       rsp_attr_o;
    logic             busy_o;

    int n_cmp = 0;
    int n_err = 0;

    pma_lookup_sched #(
        .CVA6Cfg (Cfg),
        .NrPorts (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .req_valid_i (req_valid_i),
        .req_addr_i  (req_addr_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_attr_o  (rsp_attr_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Single lookup on port p with rsp_ready held high.
    task automatic lookup(input int p, input logic [63:0] a,
                          input logic [3:0] exp, input int lat,
                          input string tag);
        logic [1:0] oh;
        oh = 2'b01 << p;
        rsp_ready_i    = 2'b11;
        req_valid_i[p] = 1'b1;
        req_addr_i[p]  = a;
        #1;
        chk({tag, "_grant"}, 64'(req_ready_o), 64'(oh));
        tick();
        req_valid_i[p] = 1'b0;
        for (int c = 1; c < lat; c++) begin
            #1;
            chk({tag, "_wait"}, 64'(rsp_valid_o), 64'd0);
            tick();
        end
        #1;
        chk({tag, "_valid"}, 64'(rsp_valid_o), 64'(oh));
        chk({tag, "_attr"}, 64'(rsp_attr_o), 64'(exp));
        tick();
        #1;
        chk({tag, "_idle"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        req_valid_i = 2'b00;
        req_addr_i  = '0;
        rsp_ready_i = 2'b00;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        chk("rst_ready", 64'(req_ready_o), 64'd0);
        chk("rst_rspv", 64'(rsp_valid_o), 64'd0);
        chk("rst_attr", 64'(rsp_attr_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);

        // Basic port-1 lookup, exec and cached hit.
        lookup(1, 64'h8000_0040, 4'b0110, LatHit, "p1_hit");

        // Both ports valid straight out of reset.
        tick();
        rst_i = 1'b1;
        tick();
        rst_i          = 1'b0;
        rsp_ready_i    = 2'b11;
        req_valid_i    = 2'b11;
        req_addr_i[0]  = 64'h800;
        req_addr_i[1]  = 64'h1000_00FF;
        #1;
        chk("both_gnt0", 64'(req_ready_o), 64'b01);
        tick();
        req_valid_i[0] = 1'b0;
        #1;
        chk("both_wait1", 64'(req_ready_o), 64'd0);
        chk("both_busy", 64'(busy_o), 64'd1);
        repeat (3) tick();
        #1;
        chk("both_v0", 64'(rsp_valid_o), 64'b01);
        chk("both_a0", 64'(rsp_attr_o), 64'b0011);
        tick();
        #1;
        chk("both_gnt1", 64'(req_ready_o), 64'b10);
        tick();
        req_valid_i[1] = 1'b0;
        repeat (3) tick();
        #1;
        chk("both_v1", 64'(rsp_valid_o), 64'b10);
        chk("both_a1", 64'(rsp_attr_o), 64'b0001);
        tick();

        // Region boundaries.
        lookup(0, 64'hBFFF_FFFF, 4'b0110, LatHit, "bnd_top");
        lookup(0, 64'hC000_0000, 4'b0000, 4, "bnd_end");
        lookup(1, 64'h1000_0100, 4'b0000, 4, "bnd_ni");

        // Backpressure on port 1 while port 0 waits.
        rsp_ready_i    = 2'b00;
        req_valid_i[1] = 1'b1;
        req_addr_i[1]  = 64'h8000_0040;
        #1;
        chk("bp_gnt1", 64'(req_ready_o), 64'b10);
        tick();
        req_valid_i    = 2'b01;
        req_addr_i[0]  = 64'h800;
        repeat (LatHit - 1) tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_valid", 64'(rsp_valid_o), 64'b10);
            chk("bp_attr", 64'(rsp_attr_o), 64'b0110);
            chk("bp_noready", 64'(req_ready_o), 64'd0);
            chk("bp_busy", 64'(busy_o), 64'd1);
            tick();
        end
        rsp_ready_i = 2'b10;
        tick();
        #1;
        chk("bp_gnt0", 64'(req_ready_o), 64'b01);
        rsp_ready_i = 2'b11;
        tick();
        req_valid_i = 2'b00;
        repeat (3) tick();
        #1;
        chk("bp_v0", 64'(rsp_valid_o), 64'b01);
        chk("bp_a0", 64'(rsp_attr_o), 64'b0011);
        tick();

        // Flush in the second scan cycle; pointer now favours port 1.
        req_valid_i = 2'b11;
        req_addr_i[1] = 64'h8000_0040;
        #1;
        chk("fl_gnt1", 64'(req_ready_o), 64'b10);
        tick();
        req_valid_i = 2'b01;
        tick();
        flush_i = 1'b1;
        #1;
        chk("fl_block", 64'(req_ready_o), 64'd0);
        tick();
        flush_i     = 1'b0;
        req_valid_i = 2'b11;
        #1;
        chk("fl_idle", 64'(busy_o), 64'd0);
        chk("fl_norsp", 64'(rsp_valid_o), 64'd0);
        chk("fl_gnt0", 64'(req_ready_o), 64'b01);

        // Reset while holding a response.
        rsp_ready_i = 2'b00;
        tick();
        req_valid_i = 2'b00;
        repeat (3) tick();
        #1;
        chk("rr_valid", 64'(rsp_valid_o), 64'b01);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        chk("rr_rspv", 64'(rsp_valid_o), 64'd0);
        chk("rr_attr", 64'(rsp_attr_o), 64'd0);
        chk("rr_busy", 64'(busy_o), 64'd0);
        chk("rr_ready", 64'(req_ready_o), 64'd0);
        req_valid_i = 2'b11;
        #1;
        chk("rr_ptr", 64'(req_ready_o), 64'b01);
        req_valid_i = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
